mem_access_stage: RTL and testbench

- MEM stage controller plus MEM/WB pipeline register; sits directly downstream of the EX/MEM register.
- Issues load/store requests to an external data memory over a req/ack handshake.
- Holds the pipeline via stall_o until the access completes, then passes results to writeback.
- Flags misaligned accesses and bus timeouts, converting the faulting instruction into a bubble.

---
 rtl/mem_access_stage_if.sv | 25 ++
 rtl/mem_access_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : mem_access_stage_if
// Brief   : Data-memory request/acknowledge bus between the MEM stage and dmem.
// Rev     : 1.0
// ---------------------------------------------------------------------------
interface mem_access_stage_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_rdata_i, dmem_ack_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output dmem_rdata_i, dmem_ack_i
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : mem_access_stage
// Brief   : MEM stage controller with MEM/WB register; req/ack data memory
//           access, misalignment drop and bus-timeout abort.
// Rev     : 1.0
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    input  wire logic [31:0] ALUout_i,
    input  wire logic [31:0] MemWriteData_i,
    input  wire logic [4:0]  RegWriteAddr_i,
    input  wire logic [1:0]  WB_i,
    input  wire logic        MemWrite_i,
    input  wire logic        MemRead_i,
    mem_access_stage_if.master dmem,
    output logic             stall_o,
    output logic             RegWrite_o,
    output logic             MemtoReg_o,
    output logic [31:0]      ReadData_o,
    output logic [31:0]      ALUout_o,
    output logic [4:0]       RegWriteAddr_o,
    output logic             misalign_o,
    output logic             bus_err_o
);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_wb;
    logic [31:0] r_alu;
    logic [4:0]  r_rd;

    logic w_op;
    logic w_aligned;
    logic w_issue;
    logic w_drop;
    logic w_pass;
    logic w_ack;
    logic w_expire;

    assign w_op      = MemRead_i | MemWrite_i;
    assign w_aligned = (ALUout_i[1:0] == 2'b00);

    assign dmem.dmem_req_o   = r_req;
    assign dmem.dmem_we_o    = r_we;
    assign dmem.dmem_addr_o  = r_addr;
    assign dmem.dmem_wdata_o = r_wdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_op && w_aligned) w_state_nxt = S_ACCESS;
            S_ACCESS: if (dmem.dmem_ack_i || (r_cnt == c_TO_LAST)) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // An ack on the final counted cycle takes priority over the timeout.
    always_comb begin
        w_issue  = 1'b0;
        w_drop   = 1'b0;
        w_pass   = 1'b0;
        w_ack    = 1'b0;
        w_expire = 1'b0;
        stall_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_op && w_aligned) begin
                    w_issue = 1'b1;
                    stall_o = 1'b1;
                end else if (w_op) begin
                    w_drop = 1'b1;
                end else begin
                    w_pass = 1'b1;
                end
            end
            S_ACCESS: begin
                if (dmem.dmem_ack_i) begin
                    w_ack = 1'b1;
                end else if (r_cnt == c_TO_LAST) begin
                    w_expire = 1'b1;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: ;
        endcase
        if (rst_i) begin
            stall_o = 1'b0;
        end
    end

    // Bus side; the writeback fields are captured at issue so completion
    // never depends on upstream still presenting the instruction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= 8'd0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wb    <= 2'b00;
            r_alu   <= 32'd0;
            r_rd    <= 5'd0;
        end else if (w_issue) begin
            r_cnt   <= 8'd0;
            r_req   <= 1'b1;
            r_we    <= MemWrite_i;
            r_addr  <= ALUout_i;
            r_wdata <= MemWriteData_i;
            r_wb    <= WB_i;
            r_alu   <= ALUout_i;
            r_rd    <= RegWriteAddr_i;
        end else if (w_ack || w_expire) begin
            r_req <= 1'b0;
        end else if (r_state == S_ACCESS) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            RegWrite_o     <= 1'b0;
            MemtoReg_o     <= 1'b0;
            ReadData_o     <= 32'd0;
            ALUout_o       <= 32'd0;
            RegWriteAddr_o <= 5'd0;
            misalign_o     <= 1'b0;
            bus_err_o      <= 1'b0;
        end else begin
            misalign_o <= w_drop;
            bus_err_o  <= w_expire;
            if (w_pass) begin
                RegWrite_o     <= WB_i[1];
                MemtoReg_o     <= WB_i[0];
                ALUout_o       <= ALUout_i;
                RegWriteAddr_o <= RegWriteAddr_i;
            end else if (w_ack) begin
                RegWrite_o     <= r_wb[1];
                MemtoReg_o     <= r_wb[0];
                ALUout_o       <= r_alu;
                RegWriteAddr_o <= r_rd;
                if (!r_we) begin
                    ReadData_o <= dmem.dmem_rdata_i;
                end
            end else begin
                RegWrite_o <= 1'b0;
                MemtoReg_o <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_mem_access_stage
// Brief   : Scoreboard bench for mem_access_stage with an instruction-level model.
// Rev     : 1.0
// ---------------------------------------------------------------------------
module tb_mem_access_stage;
    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] ALUout_i;
    logic [31:0] MemWriteData_i;
    logic [4:0]  RegWriteAddr_i;
    logic [1:0]  WB_i;
    logic        MemWrite_i;
    logic        MemRead_i;
    logic        stall_o;
    logic        RegWrite_o;
    logic        MemtoReg_o;
    logic [31:0] ReadData_o;
    logic [31:0] ALUout_o;
    logic [4:0]  RegWriteAddr_o;
    logic        misalign_o;
    logic        bus_err_o;

    always #5 clk_i = ~clk_i;

    mem_access_stage_if dmem_if();

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ALUout_i       (ALUout_i),
        .MemWriteData_i (MemWriteData_i),
        .RegWriteAddr_i (RegWriteAddr_i),
        .WB_i           (WB_i),
        .MemWrite_i     (MemWrite_i),
        .MemRead_i      (MemRead_i),
        .dmem           (dmem_if),
        .stall_o        (stall_o),
        .RegWrite_o     (RegWrite_o),
        .MemtoReg_o     (MemtoReg_o),
        .ReadData_o     (ReadData_o),
        .ALUout_o       (ALUout_o),
        .RegWriteAddr_o (RegWriteAddr_o),
        .misalign_o     (misalign_o),
        .bus_err_o      (bus_err_o)
    );

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        mis;
        logic        berr;
    } wb_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] cycles;
    } req_t;

    wb_t  wb_q[$];
    req_t req_q[$];
    wb_t  model;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // One instruction from EX/MEM; n = cycles from request to ack, n > TO means no ack.
    task automatic run_instr(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                             input logic [1:0] wb, input logic mw, input logic mr,
                             input int n, input logic [31:0] rdat);
        int    len;
        logic  mem_op;
        logic  al;
        req_t  r;
        wb_t   e;
        ALUout_i       = alu;
        MemWriteData_i = wd;
        RegWriteAddr_i = rd;
        WB_i           = wb;
        MemWrite_i     = mw;
        MemRead_i      = mr;
        mem_op = mw | mr;
        al     = (alu % 4) == 0;
        e      = model;
        e.mis  = 1'b0;
        e.berr = 1'b0;
        if (!mem_op) begin
            e.rw = wb[1]; e.m2r = wb[0]; e.alu = alu; e.rd = rd;
            len = 1;
        end else if (!al) begin
            e.rw = 1'b0; e.m2r = 1'b0; e.mis = 1'b1;
            len = 1;
        end else begin
            r.addr = alu; r.wdata = wd; r.we = mw;
            r.cycles = (n > TO) ? TO : n;
            req_q.push_back(r);
            if (n > TO) begin
                e.rw = 1'b0; e.m2r = 1'b0; e.berr = 1'b1;
                len = 1 + TO;
            end else begin
                e.rw = wb[1]; e.m2r = wb[0]; e.alu = alu; e.rd = rd;
                if (!mw) e.rdata = rdat;
                len = 1 + n;
            end
        end
        model = e;
        wb_q.push_back(e);
        for (int j = 0; j < len; j++) begin
            if (mem_op && al && j > 0 && j == n)
                dmem_if.dmem_ack_i = 1'b1;
            else
                dmem_if.dmem_ack_i = (j == 0) && ($urandom_range(3) == 0);
            dmem_if.dmem_rdata_i = (j == n) ? rdat : $urandom;
            @(negedge clk_i);
            chk("stall", {31'd0, stall_o}, {31'd0, (j < len - 1)});
            @(posedge clk_i);
            #2;
        end
        dmem_if.dmem_ack_i = 1'b0;
    endtask

    task automatic set_idle();
        ALUout_i = '0; MemWriteData_i = '0; RegWriteAddr_i = '0;
        WB_i = '0; MemWrite_i = 1'b0; MemRead_i = 1'b0;
        dmem_if.dmem_ack_i = 1'b0;
        dmem_if.dmem_rdata_i = '0;
    endtask

    // Monitor: request bus and MEM/WB retirement
    initial begin : monitor
        wb_t         e;
        wb_t         last;
        logic        retire;
        int          rc;
        last = '0;
        rc   = 0;
        forever begin
            @(negedge clk_i);
            retire = !rst_i && !stall_o;
            if (dmem_if.dmem_req_o === 1'b1) begin
                rc++;
                if (req_q.size() == 0) begin
                    if (rc == 1) fail_now("req_unexpected");
                end else begin
                    chk("req_addr",  dmem_if.dmem_addr_o,  req_q[0].addr);
                    chk("req_we",    {31'd0, dmem_if.dmem_we_o}, {31'd0, req_q[0].we});
                    chk("req_wdata", dmem_if.dmem_wdata_o, req_q[0].wdata);
                end
            end else if (rc > 0) begin
                if (req_q.size() == 0) begin
                    fail_now("req_underflow");
                end else begin
                    chk("req_cycles", rc, req_q[0].cycles);
                    void'(req_q.pop_front());
                end
                rc = 0;
            end
            @(posedge clk_i);
            #1;
            if (rst_i) begin
                last = '0;
            end else if (retire) begin
                if (wb_q.size() == 0) begin
                    fail_now("wb_underflow");
                end else begin
                    e = wb_q.pop_front();
                    chk("RegWrite",     {31'd0, RegWrite_o}, {31'd0, e.rw});
                    chk("MemtoReg",     {31'd0, MemtoReg_o}, {31'd0, e.m2r});
                    chk("ReadData",     ReadData_o, e.rdata);
                    chk("ALUout",       ALUout_o, e.alu);
                    chk("RegWriteAddr", {27'd0, RegWriteAddr_o}, {27'd0, e.rd});
                    chk("misalign",     {31'd0, misalign_o}, {31'd0, e.mis});
                    chk("bus_err",      {31'd0, bus_err_o}, {31'd0, e.berr});
                    last = e;
                end
            end else begin
                chk("bubble_RegWrite", {31'd0, RegWrite_o}, 32'd0);
                chk("bubble_MemtoReg", {31'd0, MemtoReg_o}, 32'd0);
                chk("bubble_misalign", {31'd0, misalign_o}, 32'd0);
                chk("bubble_bus_err",  {31'd0, bus_err_o}, 32'd0);
                chk("hold_ALUout",     ALUout_o, last.alu);
                chk("hold_ReadData",   ReadData_o, last.rdata);
                chk("hold_rd",         {27'd0, RegWriteAddr_o}, {27'd0, last.rd});
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int          k;
        int          p;
        int          n;
        logic [31:0] a;
        req_t        r;
        set_idle();
        model = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_req",      {31'd0, dmem_if.dmem_req_o}, 32'd0);
        chk("rst_stall",    {31'd0, stall_o}, 32'd0);
        chk("rst_RegWrite", {31'd0, RegWrite_o}, 32'd0);
        chk("rst_ALUout",   ALUout_o, 32'd0);
        chk("rst_ReadData", ReadData_o, 32'd0);
        #2;
        rst_i = 1'b0;

        run_instr(32'h1234, 32'h0, 5'd5, 2'b10, 1'b0, 1'b0, 1, 32'h0);
        run_instr(32'h100, 32'h0, 5'd7, 2'b11, 1'b0, 1'b1, 3, 32'hDEADBEEF);
        run_instr(32'h200, 32'hCAFEF00D, 5'd9, 2'b00, 1'b1, 1'b0, 1, 32'h0);
        run_instr(32'h103, 32'h0, 5'd3, 2'b11, 1'b0, 1'b1, 1, 32'h0);
        run_instr(32'h300, 32'h0, 5'd4, 2'b11, 1'b0, 1'b1, TO + 1, 32'h0);
        run_instr(32'h304, 32'h0, 5'd4, 2'b11, 1'b0, 1'b1, TO, 32'h13572468);
        run_instr(32'h308, 32'h55AA55AA, 5'd6, 2'b00, 1'b1, 1'b1, 2, 32'h0);

        // Reset in the middle of an outstanding load
        ALUout_i = 32'h40; MemWriteData_i = '0; RegWriteAddr_i = 5'd8;
        WB_i = 2'b11; MemWrite_i = 1'b0; MemRead_i = 1'b1;
        dmem_if.dmem_ack_i = 1'b0;
        r.addr = 32'h40; r.wdata = '0; r.we = 1'b0; r.cycles = 3;
        req_q.push_back(r);
        repeat (4) @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_req",      {31'd0, dmem_if.dmem_req_o}, 32'd0);
        chk("mid_rst_we",       {31'd0, dmem_if.dmem_we_o}, 32'd0);
        chk("mid_rst_addr",     dmem_if.dmem_addr_o, 32'd0);
        chk("mid_rst_stall",    {31'd0, stall_o}, 32'd0);
        chk("mid_rst_RegWrite", {31'd0, RegWrite_o}, 32'd0);
        chk("mid_rst_MemtoReg", {31'd0, MemtoReg_o}, 32'd0);
        chk("mid_rst_ReadData", ReadData_o, 32'd0);
        chk("mid_rst_ALUout",   ALUout_o, 32'd0);
        chk("mid_rst_rd",       {27'd0, RegWriteAddr_o}, 32'd0);
        set_idle();
        model = '0;
        repeat (2) @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        run_instr(32'h44, 32'h0, 5'd10, 2'b11, 1'b0, 1'b1, 2, 32'hA5A5F00F);

        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(9);
            p = $urandom_range(9);
            n = (p == 0) ? TO + 1 : (p == 1) ? TO : $urandom_range(1, 5);
            a = $urandom;
            if (k <= 3) begin
                run_instr(a, $urandom, 5'($urandom), 2'($urandom), 1'b0, 1'b0, n, $urandom);
            end else if (k == 8) begin
                a[1:0] = 2'($urandom_range(1, 3));
                run_instr(a, $urandom, 5'($urandom), 2'($urandom), 1'($urandom), 1'b1, n, $urandom);
            end else begin
                a[1:0] = 2'b00;
                run_instr(a, $urandom, 5'($urandom), 2'($urandom),
                          (k >= 6), (k <= 5) || (k == 9), n, $urandom);
            end
        end

        run_instr(32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1, 32'h0);
        run_instr(32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1, 32'h0);
        chk("wb_queue_drained",  wb_q.size(), 32'd0);
        chk("req_queue_drained", req_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
